// File: rtl/sync_fifo_16i_32o_pkg.sv
// Shared widths and thresholds for the 16-bit-in / 32-bit-out FIFO.
package sync_fifo_16i_32o_pkg;
  localparam int DEF_WR_DEPTH_WIDTH   = 12;
  localparam int DEF_WR_DATA_WIDTH    = 16;
  localparam int DEF_ALMOST_FULL_NUM  = 4092;
  localparam int DEF_ALMOST_EMPTY_NUM = 4;
  localparam int DEF_RD_DATA_WIDTH    = 2 * DEF_WR_DATA_WIDTH;
  localparam int DEF_RD_DEPTH_WIDTH   = DEF_WR_DEPTH_WIDTH - 1;
endpackage

// File: rtl/sdp_ram_16i_32o.sv
// Two half-width banks behind one row address: narrow write lane select, wide registered read.
module sdp_ram_16i_32o
  import sync_fifo_16i_32o_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH = DEF_WR_DEPTH_WIDTH,
  parameter int WR_DATA_WIDTH  = DEF_WR_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WR_DEPTH_WIDTH-1:0]   wr_addr,
  input  logic [WR_DATA_WIDTH-1:0]    wr_data,
  input  logic                        rd_en,
  input  logic [WR_DEPTH_WIDTH-2:0]   rd_addr,
  output logic [2*WR_DATA_WIDTH-1:0]  rd_data
);
  localparam int ROWS = 2 ** (WR_DEPTH_WIDTH - 1);

  // Lane [1] is bank 1, lane [0] is bank 0, so a row reads out as {bank1, bank0}.
  logic [1:0][WR_DATA_WIDTH-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[WR_DEPTH_WIDTH-1:1]][wr_addr[0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_16i_32o.sv
// Single-clock upsizing FIFO: packs pairs of narrow writes into one wide read word.
module sync_fifo_16i_32o
  import sync_fifo_16i_32o_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH   = DEF_WR_DEPTH_WIDTH,
  parameter int WR_DATA_WIDTH    = DEF_WR_DATA_WIDTH,
  parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WR_DATA_WIDTH-1:0]    wr_data,
  input  logic                        wr_en,
  output logic                        wr_full,
  output logic [WR_DEPTH_WIDTH:0]     wr_water_level,
  output logic                        almost_full,
  output logic                        wr_overflow,
  output logic [2*WR_DATA_WIDTH-1:0]  rd_data,
  input  logic                        rd_en,
  output logic                        rd_empty,
  output logic [WR_DEPTH_WIDTH-1:0]   rd_water_level,
  output logic                        almost_empty,
  output logic                        rd_underflow
);
  localparam logic [WR_DEPTH_WIDTH:0]   FULL_LVL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
  localparam logic [WR_DEPTH_WIDTH:0]   AF_LVL   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [WR_DEPTH_WIDTH-1:0] AE_LVL   = WR_DEPTH_WIDTH'(ALMOST_EMPTY_NUM);

  logic [WR_DEPTH_WIDTH:0]   wr_ptr;  // counts halves
  logic [WR_DEPTH_WIDTH-1:0] rd_ptr;  // counts wide words
  logic                      wr_acc, rd_acc;

  // Modular difference stays correct across wraps since both pointers roll together.
  assign wr_water_level = wr_ptr - {rd_ptr, 1'b0};
  assign rd_water_level = wr_water_level[WR_DEPTH_WIDTH:1];
  assign wr_full        = (wr_water_level == FULL_LVL);
  assign rd_empty       = (rd_water_level == '0);
  assign almost_full    = (wr_water_level >= AF_LVL);
  assign almost_empty   = (rd_water_level <= AE_LVL);

  assign wr_acc = wr_en && !wr_full;
  assign rd_acc = rd_en && !rd_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      wr_overflow  <= wr_en && wr_full;
      rd_underflow <= rd_en && rd_empty;
    end
  end

  sdp_ram_16i_32o #(
    .WR_DEPTH_WIDTH (WR_DEPTH_WIDTH),
    .WR_DATA_WIDTH  (WR_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[WR_DEPTH_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[WR_DEPTH_WIDTH-2:0]),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_sync_fifo_16i_32o.sv
// Scoreboard bench: driver predicts wide words into a queue, monitor pops on each accepted read.
module tb_sync_fifo_16i_32o;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        wr_full;
  logic [12:0] wr_water_level;
  logic        almost_full;
  logic        wr_overflow;
  logic [31:0] rd_data;
  logic        rd_en = 1'b0;
  logic        rd_empty;
  logic [11:0] rd_water_level;
  logic        almost_empty;
  logic        rd_underflow;

  sync_fifo_16i_32o dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
    .wr_water_level(wr_water_level), .almost_full(almost_full), .wr_overflow(wr_overflow),
    .rd_data(rd_data), .rd_en(rd_en), .rd_empty(rd_empty), .rd_water_level(rd_water_level),
    .almost_empty(almost_empty), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] mq[$];     // model of stored halves
  logic [31:0] exp_q[$];  // expected wide words, in read order

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // One clock: drive at negedge, advance model on pre-edge state, check status after the edge.
  task automatic cyc(input bit we, input logic [15:0] wd, input bit re);
    bit wacc, racc;
    int lvl;
    logic [15:0] h0, h1;
    @(negedge clk);
    wr_en = we; wr_data = wd; rd_en = re;
    wacc = we && (mq.size() < 4096);
    racc = re && (mq.size() >= 2);
    if (racc) begin
      h0 = mq.pop_front();
      h1 = mq.pop_front();
      exp_q.push_back({h1, h0});
    end
    if (wacc) mq.push_back(wd);
    @(posedge clk);
    #1;
    lvl = mq.size();
    chk("wr_water_level", 32'(wr_water_level), 32'(lvl));
    chk("rd_water_level", 32'(rd_water_level), 32'(lvl / 2));
    chk("rd_empty",       32'(rd_empty),       32'(lvl < 2));
    chk("wr_full",        32'(wr_full),        32'(lvl == 4096));
    chk("almost_full",    32'(almost_full),    32'(lvl >= 4092));
    chk("almost_empty",   32'(almost_empty),   32'((lvl / 2) <= 4));
    chk("wr_overflow",    32'(wr_overflow),    32'(we && !wacc));
    chk("rd_underflow",   32'(rd_underflow),   32'(re && !racc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    chk("rst rd_data",        rd_data, 32'h0);
    chk("rst rd_empty",       32'(rd_empty), 32'd1);
    chk("rst wr_full",        32'(wr_full), 32'd0);
    chk("rst wr_water_level", 32'(wr_water_level), 32'd0);
    chk("rst rd_water_level", 32'(rd_water_level), 32'd0);
    chk("rst almost_full",    32'(almost_full), 32'd0);
    chk("rst almost_empty",   32'(almost_empty), 32'd1);
    chk("rst overflow",       32'(wr_overflow), 32'd0);
    chk("rst underflow",      32'(rd_underflow), 32'd0);
    mq.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: a read the DUT accepts on this edge presents data from this edge.
  initial begin
    bit fire;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      fire = rd_en && !rd_empty && !rst;
      #2;
      if (fire) begin
        if (exp_q.size() == 0) chk("unexpected read", rd_data, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e);
        end
      end
    end
  end

  initial begin
    do_reset();

    // Pair 0x1111/0x2222 becomes one word with first half in the low lane.
    cyc(1, 16'h1111, 0);
    cyc(1, 16'h2222, 0);
    chk("pair rd_water_level", 32'(rd_water_level), 32'd1);
    cyc(0, 16'h0, 1);
    #1;
    chk("pair rd_data", rd_data, 32'h2222_1111);
    cyc(0, 16'h0, 0);

    // Three halves: one read, then a rejected read with data held.
    cyc(1, 16'h000A, 0);
    cyc(1, 16'h000B, 0);
    cyc(1, 16'h000C, 0);
    cyc(0, 16'h0, 1);
    #1;
    chk("odd first read", rd_data, 32'h000B_000A);
    cyc(0, 16'h0, 1);
    #1;
    chk("odd held rd_data", rd_data, 32'h000B_000A);
    chk("odd wr_water_level", 32'(wr_water_level), 32'd1);
    // Partner write completing the pair does not make a same-edge read legal.
    cyc(1, 16'h000D, 1);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);

    // Fill with descending halves, overflow, then drain.
    do_reset();
    for (int i = 0; i < 4096; i++) cyc(1, 16'(16'hFFFF - i), 0);
    chk("fill wr_full", 32'(wr_full), 32'd1);
    cyc(1, 16'h5555, 0);
    chk("ovf pulse", 32'(wr_overflow), 32'd1);
    chk("ovf level", 32'(wr_water_level), 32'd4096);
    for (int i = 0; i < 2048; i++) cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);

    // Refill, then simultaneous write+read at full.
    for (int i = 0; i < 4096; i++) cyc(1, 16'(i * 3 + 7), 0);
    cyc(1, 16'hBEEF, 1);
    chk("full rw level", 32'(wr_water_level), 32'd4094);
    cyc(1, 16'hCAFE, 1);
    chk("full rw level next", 32'(wr_water_level), 32'd4093);
    for (int i = 0; i < 2100 && mq.size() >= 2; i++) cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);

    // Continuous streaming through three pointer wraps.
    do_reset();
    for (int i = 0; i < 3 * 8192; i++) cyc(1, 16'(i ^ 16'h5A5A), 1);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 1);
    cyc(0, 16'h0, 0);

    // Reset mid-stream, then a fresh pair.
    for (int i = 0; i < 10; i++) cyc(1, 16'(16'h0100 + i), 0);
    do_reset();
    cyc(1, 16'h1234, 0);
    cyc(1, 16'h5678, 0);
    cyc(0, 16'h0, 1);
    #1;
    chk("post-rst rd_data", rd_data, 32'h5678_1234);
    cyc(0, 16'h0, 0);
    cyc(0, 16'h0, 0);

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sync_fifo_16i_32o.md
Name: sync_fifo_16i_32o

Overview:
- Single-clock FIFO that accepts 16-bit words and delivers 32-bit words.
- Performs the upsizing that is the reverse of the existing 32-in/16-out FIFO: the write side is the narrow port and the read side is the wide port.
- Used on the capture path to pack 16-bit pixel/sample streams into 32-bit words before DDR write bursts.
- Provides the same status set as the team's FIFOs: full/empty, water levels, almost_full/almost_empty.

Parameters:
- WR_DEPTH_WIDTH, 12, log2 of capacity in 16-bit words (capacity 4096 halves = 2048 wide words).
- WR_DATA_WIDTH, 16, write word width; read width is fixed at 2*WR_DATA_WIDTH.
- ALMOST_FULL_NUM, 4092, almost_full threshold in write words.
- ALMOST_EMPTY_NUM, 4, almost_empty threshold in read words.

Ports:
- clk  in  1  single clock for both sides.
- rst  in  1  reset, asynchronous, active-high.
- wr_data  in  WR_DATA_WIDTH  write word.
- wr_en  in  1  write request.
- wr_full  out  1  no room for a write word.
- wr_water_level  out  WR_DEPTH_WIDTH+1  stored halves.
- almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM.
- wr_overflow  out  1  one-cycle pulse: wr_en while full.
- rd_data  out  2*WR_DATA_WIDTH  read word.
- rd_en  in  1  read request.
- rd_empty  out  1  fewer than two halves stored.
- rd_water_level  out  WR_DEPTH_WIDTH  complete wide words stored = wr_water_level>>1.
- almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM.
- rd_underflow  out  1  one-cycle pulse: rd_en while empty.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers = 0, rd_data = 0.
  - wr_full = 0, rd_empty = 1, almost_full = 0, almost_empty = 1.
  - Both water levels = 0; overflow/underflow = 0.
- Pointers:
  - wr_ptr counts halves (WR_DEPTH_WIDTH+1 bits); rd_ptr counts wide words (WR_DEPTH_WIDTH bits).
  - Both wrap naturally modulo 2^width.
  - wr_water_level = wr_ptr - {rd_ptr,1'b0}, computed mod 2^(WR_DEPTH_WIDTH+1).
- Packing order:
  - An even wr_ptr goes to bank 0, an odd wr_ptr goes to bank 1.
  - rd_data = {bank1, bank0}, so the first-written half appears in rd_data[15:0].
- Accepted write: wr_en && !wr_full, evaluated on pre-edge state. Accepted read: rd_en && !rd_empty, evaluated on pre-edge state.
- Read latency: rd_data updates on the edge where the read is accepted; data is valid from that edge, i.e. the cycle after rd_en is sampled. rd_data holds its value when no read is accepted.
- Status outputs are decoded from registered pointers, so they reflect post-edge state with no extra lag.
- Odd occupancy: a single pending half keeps rd_empty = 1 and rd_water_level = 0, while wr_water_level = 1. It becomes readable once its partner half is written.
- Simultaneous read and write:
  - Both are legal when individually accepted; wr_water_level changes by +1 - 2 = -1.
  - At full, a write is rejected even if a read is accepted on the same edge.
  - At empty with one pending half, the read is rejected even if a write completes the pair on the same edge; the pair is readable next cycle.
- Illegal requests: write-on-full and read-on-empty are dropped, pointers and memory are unchanged, and the corresponding overflow/underflow pulse fires for 1 cycle.
- Reset mid-operation: contents are discarded, and an in-flight half pair is lost. No output may glitch to X; rd_data returns to 0.

Decomposition:
- Shared package/header holds:
  - Default widths and depth.
  - Threshold constants.
  - The derived RD_DATA_WIDTH = 2*WR_DATA_WIDTH and RD_DEPTH_WIDTH = WR_DEPTH_WIDTH-1.
- One sub-module, sdp_ram_16i_32o: two 2^(WR_DEPTH_WIDTH-1) x 16 banks with a half-width write port (bank select = wr_addr[0]) and a registered full-width read port. The top level owns pointers, flags and pulses.

Test Plan:
- Reset, then write 0x1111 and 0x2222 on consecutive cycles:
  - rd_empty falls after the 2nd write edge; rd_water_level = 1.
  - rd_en for 1 cycle gives rd_data = 0x2222_1111 on the following cycle; rd_empty returns to 1.
- Write 3 halves (0xA, 0xB, 0xC), then issue 2 reads:
  - First read returns 0x000B_000A.
  - Second read is rejected with rd_underflow = 1 and rd_data held; wr_water_level = 1.
- Write 4096 descending halves from 0xFFFF:
  - almost_full rises when wr_water_level reaches 4092; wr_full rises at 4096.
  - A 4097th write gives wr_overflow = 1 and the level stays 4096.
  - Drain 2048 reads and check every word = {cnt-1, cnt}.
- At full, assert wr_en and rd_en on the same cycle: the write is rejected and wr_water_level = 4094. Next cycle, the same pair is accepted and the level becomes 4093.
- Stream continuous writes with rd_en held high for 3 wraps of both pointers: no data error, no overflow, rd_water_level stays <= 1.
- Assert rst after 10 writes mid-stream: rd_data = 0, rd_empty = 1, both levels = 0, and the next pair written reads back correctly.
